// File: rtl/nn_input_feeder.sv
// nn_input_feeder: streams a block of samples from a 1-cycle-latency sample memory
// onto a valid/ready channel. A 2-entry output buffer hides the read latency and
// absorbs backpressure while still sustaining one sample per cycle.
module nn_input_feeder #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_samples,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    input  logic              ready,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StFinish = 2'd2;

    localparam logic [ADDR_W:0] CntOne  = 1;
    localparam logic [ADDR_W:0] CntZero = '0;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic [ADDR_W:0]   accepted_q, accepted_d;
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              pop;
    logic              push;
    logic [2:0]        committed;
    logic [ADDR_W-1:0] cur_addr;

    // Output handshake and read-issue decision.
    always_comb begin
        valid     = (occ_q != 2'd0);
        data      = buf0_q;
        busy      = (state_q == StRun);
        done      = (state_q == StFinish);
        pop       = valid & ready;
        push      = inflight_q;
        // Entries that will be held once the outstanding read lands and this pop leaves.
        committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        cur_addr  = base_q + issued_q[ADDR_W-1:0];
        mem_rd_en = (state_q == StRun) && (issued_q < num_q) && (committed < 3'd2);
        mem_addr  = mem_rd_en ? cur_addr : addr_q;
    end

    // Control FSM and transfer counters.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        addr_d     = mem_addr;
        inflight_d = mem_rd_en;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d     = base_addr;
                    num_d      = num_samples;
                    issued_d   = CntZero;
                    accepted_d = CntZero;
                    state_d    = (num_samples == CntZero) ? StFinish : StRun;
                end
            end
            StRun: begin
                if (mem_rd_en) begin
                    issued_d = issued_q + CntOne;
                end
                if (pop) begin
                    accepted_d = accepted_q + CntOne;
                    if (accepted_q + CntOne == num_q) begin
                        state_d = StFinish;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Two-entry output buffer: buf0 is the head, buf1 the second slot.
    always_comb begin
        occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (pop && push) begin
            if (occ_q == 2'd1) begin
                buf0_d = mem_rd_data;
            end else begin
                buf0_d = buf1_q;
                buf1_d = mem_rd_data;
            end
        end else if (pop) begin
            buf0_d = buf1_q;
        end else if (push) begin
            if (occ_q == 2'd0) begin
                buf0_d = mem_rd_data;
            end else begin
                buf1_d = mem_rd_data;
            end
        end
    end

    // State registers; reset also drops any read still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            base_q     <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: tb/tb_nn_input_feeder.sv
// Directed bench for nn_input_feeder; sample memory holds mem[a] = a + 1.
module tb_nn_input_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] num_samples;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       busy;
    logic       done;

    int checks = 0;
    int passes = 0;

    nn_input_feeder #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_samples(num_samples),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .valid      (valid),
        .data       (data),
        .ready      (ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read sample memory model.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_addr + 8'd1;
    end

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = 8'h00; num_samples = 9'd0; ready = 1'b0;
        mem_rd_data = 8'h00;
        #12;
        checks++; if ({valid, mem_rd_en, busy, done} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b want 0000", {valid, mem_rd_en, busy, done});
            else passes++;
        checks++; if ({data, mem_addr} !== 16'h0000)
            $display("FAIL reset_bus: got %h want 0000", {data, mem_addr}); else passes++;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
    endtask

    // ready held high: reads cycles 1..num, data cycles 3..num+2, done cycle num+3.
    task automatic test_stream(input string name, input logic [7:0] base, input int num);
        logic [7:0] ea, ed;
        logic       er, ev;
        @(negedge clk); start = 1'b1; base_addr = base; num_samples = 9'(num); ready = 1'b1;
        for (int c = 1; c <= num + 4; c++) begin
            @(negedge clk); start = 1'b0; #1;
            ea = base + 8'(c - 1);
            ed = base + 8'(c - 3) + 8'd1;
            er = (c <= num);
            ev = (c >= 3) && (c <= num + 2);
            checks++; if (mem_rd_en !== er)
                $display("FAIL %s rd_en c%0d: got %b want %b", name, c, mem_rd_en, er);
                else passes++;
            if (er) begin
                checks++; if (mem_addr !== ea)
                    $display("FAIL %s addr c%0d: got %h want %h", name, c, mem_addr, ea);
                    else passes++;
            end
            checks++; if (valid !== ev)
                $display("FAIL %s valid c%0d: got %b want %b", name, c, valid, ev); else passes++;
            if (ev) begin
                checks++; if (data !== ed)
                    $display("FAIL %s data c%0d: got %h want %h", name, c, data, ed);
                    else passes++;
            end
            checks++; if (done !== 1'(c == num + 3))
                $display("FAIL %s done c%0d: got %b", name, c, done); else passes++;
            checks++; if (busy !== 1'(c <= num + 2))
                $display("FAIL %s busy c%0d: got %b", name, c, busy); else passes++;
        end
    endtask

    task automatic test_zero_length();
        @(negedge clk); start = 1'b1; base_addr = 8'h55; num_samples = 9'd0; ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); start = 1'b0; #1;
            checks++; if (done !== 1'(c == 1))
                $display("FAIL zero done c%0d: got %b", c, done); else passes++;
            checks++; if ({mem_rd_en, valid, busy} !== 3'b000)
                $display("FAIL zero ctrl c%0d: got %b want 000", c, {mem_rd_en, valid, busy});
                else passes++;
        end
    endtask

    task automatic test_backpressure();
        bit         rdy [1:9] = '{1, 0, 0, 1, 0, 1, 1, 1, 1};
        bit         erd [1:9] = '{1, 1, 0, 1, 0, 0, 0, 0, 0};
        bit         evl [1:9] = '{0, 0, 1, 1, 1, 1, 1, 0, 0};
        logic [7:0] ead [1:9] = '{8'h40, 8'h41, 8'h41, 8'h42, 8'h42, 8'h42, 8'h42, 8'h42, 8'h42};
        logic [7:0] edt [1:9] = '{8'h00, 8'h00, 8'h41, 8'h41, 8'h42, 8'h42, 8'h43, 8'h00, 8'h00};
        int         xfers = 0;
        @(negedge clk); start = 1'b1; base_addr = 8'h40; num_samples = 9'd3; ready = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk); start = 1'b0; ready = rdy[c]; #1;
            checks++; if (mem_rd_en !== erd[c])
                $display("FAIL bp rd_en c%0d: got %b want %b", c, mem_rd_en, erd[c]); else passes++;
            if (c <= 4) begin
                checks++; if (mem_addr !== ead[c])
                    $display("FAIL bp addr c%0d: got %h want %h", c, mem_addr, ead[c]);
                    else passes++;
            end
            checks++; if (valid !== evl[c])
                $display("FAIL bp valid c%0d: got %b want %b", c, valid, evl[c]); else passes++;
            if (evl[c]) begin
                checks++; if (data !== edt[c])
                    $display("FAIL bp data c%0d: got %h want %h", c, data, edt[c]); else passes++;
            end
            checks++; if (done !== 1'(c == 8))
                $display("FAIL bp done c%0d: got %b", c, done); else passes++;
            if (valid && ready) xfers++;
        end
        checks++; if (xfers != 3)
            $display("FAIL bp transfers: got %0d want 3", xfers); else passes++;
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        @(negedge clk); start = 1'b1; base_addr = 8'h20; num_samples = 9'd5; ready = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = (c == 3) || (c == 8);
            if (start) begin base_addr = 8'h80; num_samples = 9'd2; end
            #1;
            checks++; if (mem_rd_en !== 1'(c <= 5))
                $display("FAIL busy_start rd_en c%0d: got %b", c, mem_rd_en); else passes++;
            if (c <= 5) begin
                checks++; if (mem_addr !== 8'(8'h20 + c - 1))
                    $display("FAIL busy_start addr c%0d: got %h want %h", c, mem_addr,
                             8'(8'h20 + c - 1));
                    else passes++;
            end
            if (c >= 3 && c <= 7) begin
                checks++; if (data !== 8'(8'h21 + c - 3))
                    $display("FAIL busy_start data c%0d: got %h want %h", c, data,
                             8'(8'h21 + c - 3));
                    else passes++;
            end
            checks++; if (busy !== 1'(c <= 7))
                $display("FAIL busy_start busy c%0d: got %b", c, busy); else passes++;
            if (done) dones++;
        end
        start = 1'b0;
        checks++; if (dones != 1)
            $display("FAIL busy_start done_count: got %0d want 1", dones); else passes++;
    endtask

    task automatic test_reset_mid_stream();
        @(negedge clk); start = 1'b1; base_addr = 8'h30; num_samples = 9'd5; ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); start = 1'b0;
        end
        // Cycle 5: two samples taken, the read of 0x33 is in flight.
        @(negedge clk); reset = 1'b1; #1;
        checks++; if ({valid, mem_rd_en, busy, done} !== 4'b0000)
            $display("FAIL midrst ctrl: got %b want 0000", {valid, mem_rd_en, busy, done});
            else passes++;
        checks++; if ({data, mem_addr} !== 16'h0000)
            $display("FAIL midrst bus: got %h want 0000", {data, mem_addr}); else passes++;
        @(negedge clk); reset = 1'b0;
        test_stream("after_reset", 8'h60, 2);
    endtask

    initial begin
        test_reset();
        test_stream("basic", 8'h10, 4);
        test_backpressure();
        test_zero_length();
        test_stream("wrap", 8'hFE, 4);
        test_start_while_busy();
        test_reset_mid_stream();
        test_stream("full", 8'h00, 256);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/nn_input_feeder.md
Name: nn_input_feeder

Overview:
- Producer end of the accelerator input handshake: streams NUM input samples from a synchronous-read sample memory onto valid/data toward the accelerator pipeline controller, honouring its ready.
- Sits between the sample buffer (1-cycle read latency) and the accelerator input stage.
- Internal 2-entry output buffer absorbs read latency and backpressure, sustaining 1 sample/cycle when ready is held high.

Parameters:
- DATA_W, 8, sample width in bits.
- ADDR_W, 8, sample memory address width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle command pulse; sampled only in IDLE.
- base_addr  input  ADDR_W  first sample address; captured on accepted start.
- num_samples  input  ADDR_W+1  samples to send, 0..2^ADDR_W; captured on accepted start.
- mem_rd_en  output  1  memory read strobe.
- mem_addr  output  ADDR_W  memory read address.
- mem_rd_data  input  DATA_W  read data, valid the cycle after mem_rd_en.
- valid  output  1  sample valid toward accelerator.
- data  output  DATA_W  sample toward accelerator.
- ready  input  1  accelerator can accept.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async): state IDLE; counters and buffer cleared; valid=0, data=0, mem_rd_en=0, mem_addr=0, busy=0, done=0. In-flight read data is discarded.
- States: IDLE, RUN, FINISH.
  - IDLE: start=1 captures base_addr/num_samples. If num_samples=0 go to FINISH, else go to RUN.
  - RUN: issue reads and emit samples. When the accepted count reaches num_samples (on the final handshake), go to FINISH.
  - FINISH: done=1 for exactly one cycle, then return to IDLE.
- busy: 1 in RUN; 0 in IDLE and FINISH.
- start outside IDLE is ignored; it does not restart or re-capture inputs.
- Read issue, combinational in RUN: mem_rd_en=1 when both hold:
  - issued < num_samples;
  - (occupancy + inflight - pop) < 2, where pop = valid & ready this cycle.
- mem_addr = base_addr + issued, modulo 2^ADDR_W (wraps).
- mem_addr holds its last value when mem_rd_en=0.
- mem_rd_data is written into the buffer at the end of the cycle after mem_rd_en. The buffer never overflows.
- valid = occupancy > 0. data = buffer head, registered.
- Handshake: a transfer occurs on the clk edge where valid & ready.
  - valid and data stay stable until accepted; valid never drops without a transfer.
  - ready may toggle freely.
- Ordering: samples are emitted strictly in address order, with no duplication or loss.
- Latency: start in cycle 0 -> mem_rd_en, addr=base in cycle 1 -> valid=1 in cycle 3.
  - With ready held high, one sample transfers per cycle from cycle 3 onward.
- done is asserted in the cycle after the final handshake.
- num_samples=0: done in cycle 1. No mem_rd_en and no valid are produced.
- Simultaneous push (read return) and pop (transfer) in the same cycle are both honoured; occupancy stays constant.
- A start arriving in the same cycle as done (FINISH) is ignored; a new start is accepted from IDLE only.
- Counters issued and accepted are ADDR_W+1 bits wide, so count 2^ADDR_W is supported.

Test Plan:
- Basic, ready=1: base=0x10, num=4, mem[a]=a+1 -> mem_rd_en cycles 1-4 at addr 0x10-0x13; data 0x11,0x12,0x13,0x14 in cycles 3-6; done in cycle 7; busy high cycles 1-6.
- Backpressure: num=3, ready toggled 1,0,0,1,0,1 -> exactly 3 transfers in order; valid/data held during ready=0; at most 2 reads outstanding plus buffered at any time; done the cycle after the 3rd handshake.
- Zero length: start with num=0 -> done=1 in cycle 1; mem_rd_en, valid and busy stay 0.
- Wrap: ADDR_W=8, base=0xFE, num=4 -> addresses 0xFE,0xFF,0x00,0x01; data delivered in that order.
- Start while busy: second start mid-transfer with a different base/num -> ignored; the original sequence completes unchanged; only one done pulse.
- Reset mid-stream: assert reset after 2 of 5 transfers with a read in flight -> all outputs 0 immediately. A new start after reset begins cleanly from its own base_addr with no stale data.
